// File: rtl/sig_pipe_hs.sv
// Elastic valid/ready delay line: DEPTH register stages with bubble collapse, synchronous flush and occupancy.
// Define SIG_PIPE_SKID_EN to add a one-entry skid register after the last stage (cuts out_rdy -> in_rdy path).
module sig_pipe_hs #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   localparam int CW = $clog2(DEPTH + 2)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             flush,
   input  logic             in_vld,
   output logic             in_rdy,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_vld,
   input  logic             out_rdy,
   output logic [WIDTH-1:0] out_data,
   output logic [CW-1:0]    occ
);

   logic             tail_vld;
   logic [WIDTH-1:0] tail_data;
   logic             tail_rdy;
   logic [CW-1:0]    pipe_cnt;

   generate
      if (DEPTH == 0) begin : g_pass
         // flush masks the passthrough so nothing crosses during the flush cycle
         assign tail_vld  = in_vld & ~flush;
         assign tail_data = in_data;
         assign in_rdy    = tail_rdy & ~flush;
         assign pipe_cnt  = '0;
      end else begin : g_stages
         logic [DEPTH:1]   vld_q;
         logic [WIDTH-1:0] data_q [1:DEPTH];
         logic [DEPTH+1:1] rdy;
         logic [DEPTH-1:0] v_src;
         logic [WIDTH-1:0] d_src [DEPTH];

         always_comb begin
            v_src[0] = in_vld;
            d_src[0] = in_data;
            for (int k = 1; k < DEPTH; k++) begin
               v_src[k] = vld_q[k];
               d_src[k] = data_q[k];
            end
            rdy[DEPTH+1] = tail_rdy;
            for (int k = DEPTH; k >= 1; k--) begin
               rdy[k] = ~vld_q[k] | rdy[k+1];
            end
         end

         // data only loads on a real transfer so idle stages stay quiet
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               vld_q <= '0;
               for (int k = 1; k <= DEPTH; k++) data_q[k] <= '0;
            end else if (flush) begin
               vld_q <= '0;
               for (int k = 1; k <= DEPTH; k++) data_q[k] <= '0;
            end else begin
               for (int k = 1; k <= DEPTH; k++) begin
                  if (rdy[k]) begin
                     vld_q[k] <= v_src[k-1];
                     if (v_src[k-1]) data_q[k] <= d_src[k-1];
                  end
               end
            end
         end

         always_comb begin
            pipe_cnt = '0;
            for (int k = 1; k <= DEPTH; k++) pipe_cnt = pipe_cnt + CW'(vld_q[k]);
         end

         assign tail_vld  = vld_q[DEPTH];
         assign tail_data = data_q[DEPTH];
         assign in_rdy    = rdy[1] & ~flush;
      end
   endgenerate

`ifdef SIG_PIPE_SKID_EN
   logic             skid_vld;
   logic [WIDTH-1:0] skid_data;

   assign tail_rdy = ~skid_vld;

   // skid catches the tail beat on a stall and drains before the tail moves again
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         skid_vld  <= 1'b0;
         skid_data <= '0;
      end else if (flush) begin
         skid_vld  <= 1'b0;
         skid_data <= '0;
      end else if (skid_vld) begin
         if (out_rdy) skid_vld <= 1'b0;
      end else if (tail_vld && !out_rdy) begin
         skid_vld  <= 1'b1;
         skid_data <= tail_data;
      end
   end

   assign out_vld  = skid_vld | tail_vld;
   assign out_data = skid_vld ? skid_data : (tail_vld ? tail_data : '0);
   assign occ      = pipe_cnt + CW'(skid_vld);
`else
   assign tail_rdy = out_rdy;
   assign out_vld  = tail_vld;
   assign out_data = tail_vld ? tail_data : '0;
   assign occ      = pipe_cnt;
`endif

endmodule

// File: tb/tb_sig_pipe_hs.sv
// Self-checking bench for sig_pipe_hs (WIDTH=8, DEPTH=3); reference model is a queue of beats with ages.
module tb_sig_pipe_hs;
   localparam int WIDTH = 8;
   localparam int DEPTH = 3;
   localparam int CW    = $clog2(DEPTH + 2);
`ifdef SIG_PIPE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif
   localparam int CAP = DEPTH + (SKID ? 1 : 0);

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             flush = 1'b0;
   logic             in_vld = 1'b0;
   logic             in_rdy;
   logic [WIDTH-1:0] in_data = '0;
   logic             out_vld;
   logic             out_rdy = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic [CW-1:0]    occ;

   int n_tests = 0;
   int n_fail  = 0;

   // model: each accepted beat with the number of edges since it was accepted
   logic [WIDTH-1:0] q_data[$];
   int               q_age[$];

   sig_pipe_hs #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rstn(rstn), .flush(flush),
      .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
      .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
      .occ(occ)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic exp_in_rdy();
      return !flush && ((q_data.size() < CAP) || (out_rdy && !SKID));
   endfunction

   function automatic logic exp_out_vld();
      return (q_data.size() > 0) && (q_age[0] >= DEPTH);
   endfunction

   function automatic logic [WIDTH-1:0] exp_out_data();
      return exp_out_vld() ? q_data[0] : '0;
   endfunction

   task automatic model_clear();
      q_data.delete();
      q_age.delete();
   endtask

   task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
      in_vld  = v;
      in_data = d;
      out_rdy = r;
      flush   = f;
      #1;
   endtask

   task automatic tick();
      logic acc_in, acc_out, fl;
      logic [WIDTH-1:0] d;
      acc_in  = in_vld & exp_in_rdy();
      acc_out = exp_out_vld() & out_rdy;
      fl      = flush;
      d       = in_data;
      @(posedge clk);
      if (fl) begin
         model_clear();
      end else begin
         if (acc_out) begin
            void'(q_data.pop_front());
            void'(q_age.pop_front());
         end
         if (acc_in) begin
            q_data.push_back(d);
            q_age.push_back(0);
         end
      end
      foreach (q_age[i]) q_age[i] = q_age[i] + 1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      drive(1'b0, '0, 1'b0, 1'b0);
      n_tests++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_out_vld: got %b want 0", out_vld); end
      n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h want 00", out_data); end
      n_tests++; if (occ !== 3'd0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", occ); end
      @(negedge clk);
      rstn = 1'b1;
      #1;
      n_tests++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_in_rdy: got %b want 1", in_rdy); end
      model_clear();
   endtask

   task automatic test_latency();
      logic [WIDTH-1:0] vals [3];
      int occ_max;
      vals = '{8'h11, 8'h22, 8'h33};
      occ_max = 0;
      for (int c = 0; c < 8; c++) begin
         drive(c < 3, (c < 3) ? vals[c] : 8'h00, 1'b1, 1'b0);
         n_tests++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL latency_in_rdy c%0d: got %b want 1", c, in_rdy); end
         if (c >= 3 && c < 6) begin
            n_tests++; if (out_vld !== 1'b1 || out_data !== vals[c-3]) begin n_fail++;
               $display("FAIL latency_out c%0d: got vld=%b data=%h want vld=1 data=%h", c, out_vld, out_data, vals[c-3]); end
         end else begin
            n_tests++; if (out_vld !== 1'b0 || out_data !== 8'h00) begin n_fail++;
               $display("FAIL latency_idle c%0d: got vld=%b data=%h want vld=0 data=00", c, out_vld, out_data); end
         end
         if (int'(occ) > occ_max) occ_max = int'(occ);
         tick();
      end
      n_tests++; if (occ_max != 3) begin n_fail++; $display("FAIL latency_occ_peak: got %0d want 3", occ_max); end
   endtask

   task automatic test_backpressure();
      for (int c = 0; c < 4; c++) begin
         drive(1'b1, WIDTH'(c + 1), 1'b0, 1'b0);
         n_tests++; if (in_rdy !== (c < CAP)) begin n_fail++; $display("FAIL bp_in_rdy c%0d: got %b want %b", c, in_rdy, (c < CAP)); end
         tick();
      end
      drive(1'b0, '0, 1'b0, 1'b0);
      n_tests++; if (occ !== CW'(CAP)) begin n_fail++; $display("FAIL bp_occ_full: got %0d want %0d", occ, CAP); end
      n_tests++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_in_rdy_full: got %b want 0", in_rdy); end
      for (int c = 0; c < CAP; c++) begin
         drive(1'b0, '0, 1'b1, 1'b0);
         n_tests++; if (out_vld !== 1'b1 || out_data !== WIDTH'(c + 1)) begin n_fail++;
            $display("FAIL bp_drain c%0d: got vld=%b data=%h want vld=1 data=%h", c, out_vld, out_data, WIDTH'(c + 1)); end
         tick();
      end
      drive(1'b0, '0, 1'b1, 1'b0);
      n_tests++; if (out_vld !== 1'b0 || occ !== 3'd0) begin n_fail++;
         $display("FAIL bp_empty: got vld=%b occ=%0d want vld=0 occ=0", out_vld, occ); end
   endtask

   task automatic test_bubble();
      drive(1'b1, 8'hA0, 1'b0, 1'b0); tick();
      drive(1'b0, '0, 1'b0, 1'b0);    tick();
      drive(1'b0, '0, 1'b0, 1'b0);    tick();
      drive(1'b1, 8'hB0, 1'b0, 1'b0);
      n_tests++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL bubble_accept: got %b want 1", in_rdy); end
      tick();
      for (int c = 0; c < 2; c++) begin
         drive(1'b0, '0, 1'b0, 1'b0);
         n_tests++; if (occ !== 3'd2 || in_rdy !== 1'b1) begin n_fail++;
            $display("FAIL bubble_hold c%0d: got occ=%0d in_rdy=%b want occ=2 in_rdy=1", c, occ, in_rdy); end
         n_tests++; if (out_vld !== 1'b1 || out_data !== 8'hA0) begin n_fail++;
            $display("FAIL bubble_out c%0d: got vld=%b data=%h want vld=1 data=a0", c, out_vld, out_data); end
         tick();
      end
   endtask

   task automatic test_flush();
      drive(1'b1, 8'hCC, 1'b0, 1'b1);
      n_tests++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL flush_in_rdy: got %b want 0", in_rdy); end
      n_tests++; if (out_vld !== 1'b1 || out_data !== 8'hA0) begin n_fail++;
         $display("FAIL flush_preview: got vld=%b data=%h want vld=1 data=a0", out_vld, out_data); end
      tick();
      drive(1'b0, '0, 1'b1, 1'b0);
      n_tests++; if (occ !== 3'd0 || out_vld !== 1'b0 || out_data !== 8'h00) begin n_fail++;
         $display("FAIL flush_clear: got occ=%0d vld=%b data=%h want 0/0/00", occ, out_vld, out_data); end
      for (int c = 0; c < 6; c++) begin
         drive(1'b0, '0, 1'b1, 1'b0);
         n_tests++; if (out_vld !== 1'b0) begin n_fail++;
            $display("FAIL flush_leak c%0d: got vld=%b data=%h want vld=0", c, out_vld, out_data); end
         tick();
      end
   endtask

   task automatic test_full_stream();
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, WIDTH'(8'h50 + c), 1'b0, 1'b0);
         tick();
      end
      for (int c = 0; c < 8; c++) begin
         drive(1'b1, WIDTH'(8'h60 + c), 1'b1, 1'b0);
         n_tests++; if (in_rdy !== 1'b1 || out_vld !== 1'b1 || occ !== 3'd3) begin n_fail++;
            $display("FAIL stream_flow c%0d: got in_rdy=%b vld=%b occ=%0d want 1/1/3", c, in_rdy, out_vld, occ); end
         n_tests++; if (out_data !== exp_out_data()) begin n_fail++;
            $display("FAIL stream_data c%0d: got %h want %h", c, out_data, exp_out_data()); end
         tick();
      end
      for (int c = 0; c < 6; c++) begin
         drive(1'b0, '0, 1'b1, 1'b0);
         tick();
      end
      n_tests++; if (occ !== 3'd0) begin n_fail++; $display("FAIL stream_drained: got occ=%0d want 0", occ); end
   endtask

   task automatic test_async_reset();
      drive(1'b1, 8'h71, 1'b0, 1'b0); tick();
      drive(1'b1, 8'h72, 1'b0, 1'b0); tick();
      drive(1'b0, '0, 1'b0, 1'b0);
      n_tests++; if (occ !== 3'd2) begin n_fail++; $display("FAIL arst_pre_occ: got %0d want 2", occ); end
      #1;
      rstn = 1'b0;
      #1;
      n_tests++; if (out_vld !== 1'b0 || out_data !== 8'h00 || occ !== 3'd0) begin n_fail++;
         $display("FAIL arst_immediate: got vld=%b data=%h occ=%0d want 0/00/0", out_vld, out_data, occ); end
      model_clear();
      @(negedge clk);
      rstn = 1'b1;
      for (int c = 0; c < 6; c++) begin
         drive(c == 0, 8'h5A, 1'b1, 1'b0);
         if (c == 3) begin
            n_tests++; if (out_vld !== 1'b1 || out_data !== 8'h5A) begin n_fail++;
               $display("FAIL arst_first_out: got vld=%b data=%h want vld=1 data=5a", out_vld, out_data); end
         end else begin
            n_tests++; if (out_vld !== 1'b0) begin n_fail++;
               $display("FAIL arst_no_beat c%0d: got vld=%b data=%h want vld=0", c, out_vld, out_data); end
         end
         tick();
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 500; c++) begin
         drive($urandom_range(0, 9) < 7, WIDTH'($urandom), $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
         n_tests++; if (in_rdy !== exp_in_rdy()) begin n_fail++;
            $display("FAIL rand_in_rdy c%0d: got %b want %b", c, in_rdy, exp_in_rdy()); end
         n_tests++; if (out_vld !== exp_out_vld() || out_data !== exp_out_data()) begin n_fail++;
            $display("FAIL rand_out c%0d: got vld=%b data=%h want vld=%b data=%h", c, out_vld, out_data, exp_out_vld(), exp_out_data()); end
         n_tests++; if (occ !== CW'(q_data.size())) begin n_fail++;
            $display("FAIL rand_occ c%0d: got %0d want %0d", c, occ, q_data.size()); end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_backpressure();
      test_bubble();
      test_flush();
      test_full_stream();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
